// File: rtl/wrapper_pkg.sv
// Shared types and constants for the convolution-stage sliding-window generator.
package wrapper_pkg;

    localparam int DATA_W    = 16;
    localparam int WIN       = 3;
    localparam int DEF_DEPTH = 64;

    typedef logic signed [DATA_W-1:0] pixel_t [DEF_DEPTH];

    typedef enum logic {
        STRIDE1 = 1'b0,
        STRIDE2 = 1'b1
    } mode_t;

endpackage

// File: rtl/wrapper_line_buffer.sv
// Two-row line buffer: combinational read of rows r-1/r-2 at a column, then
// shift-in of the new pixel on the clock edge.
module wrapper_line_buffer
    import wrapper_pkg::*;
#(
    parameter int FM_DEPTH = 64,
    parameter int FM_WIDTH = 56
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(FM_WIDTH)-1:0]   col,
    input  logic signed [DATA_W-1:0]      din  [FM_DEPTH],
    output logic signed [DATA_W-1:0]      row1 [FM_DEPTH],
    output logic signed [DATA_W-1:0]      row2 [FM_DEPTH]
);

    logic signed [DATA_W-1:0] lb1 [FM_WIDTH][FM_DEPTH];
    logic signed [DATA_W-1:0] lb2 [FM_WIDTH][FM_DEPTH];

    always_comb begin
        for (int unsigned ch = 0; ch < FM_DEPTH; ch++) begin
            row1[ch] = lb1[col][ch];
            row2[ch] = lb2[col][ch];
        end
    end

    // Contents are never cleared; the window masking hides stale rows.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned ch = 0; ch < FM_DEPTH; ch++) begin
                lb2[col][ch] <= lb1[col][ch];
                lb1[col][ch] <= din[ch];
            end
        end
    end

endmodule

// File: rtl/wrapper.sv
// Sliding-window generator: emits a zero-padded 3x3 window and a 2x2 shortcut
// window per channel for every accepted raster pixel (stride 1 or 2).
module wrapper
    import wrapper_pkg::*;
#(
    parameter int FM_DEPTH  = 64,
    parameter int FM_WIDTH  = 56,
    parameter int CORE_SIZE = 9
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      verticle_sync,
    input  logic                      mode_in,
    input  logic                      data_in_valid,
    input  logic signed [DATA_W-1:0]  data_in  [FM_DEPTH],
    output logic                      data_out_valid,
    output logic                      vs_next,
    output logic signed [DATA_W-1:0]  data_out [FM_DEPTH][CORE_SIZE],
    output logic signed [DATA_W-1:0]  C        [FM_DEPTH][4]
);

    localparam int CW = $clog2(FM_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(FM_WIDTH - 1);

    logic [CW-1:0] col, row, eff_col, eff_row;
    mode_t         mode, eff_mode;
    logic          armed, eff_arm, at_row_end, wrap, fire;
    logic          col1_ok, col2_ok;
    logic [WIN-1:0] row_ok;

    logic signed [DATA_W-1:0] lb_r1 [FM_DEPTH];
    logic signed [DATA_W-1:0] lb_r2 [FM_DEPTH];
    logic signed [DATA_W-1:0] nc  [WIN][FM_DEPTH];
    logic signed [DATA_W-1:0] w1  [WIN][FM_DEPTH];
    logic signed [DATA_W-1:0] w2  [WIN][FM_DEPTH];
    logic signed [DATA_W-1:0] win [FM_DEPTH][WIN*WIN];

    // A sync in the same cycle as a valid makes that pixel (0,0) of the new frame.
    always_comb begin
        eff_col    = verticle_sync ? '0 : col;
        eff_row    = verticle_sync ? '0 : row;
        eff_mode   = verticle_sync ? mode_t'(mode_in) : mode;
        eff_arm    = verticle_sync | armed;
        at_row_end = (eff_col == LAST);
        wrap       = at_row_end && (eff_row == LAST);
        row_ok[0]  = (eff_row > CW'(1));
        row_ok[1]  = (eff_row != '0);
        row_ok[2]  = 1'b1;
        col2_ok    = (eff_col > CW'(1));
        col1_ok    = (eff_col != '0);
        fire       = data_in_valid &&
                     ((eff_mode == STRIDE1) || (eff_row[0] && eff_col[0]));
    end

    wrapper_line_buffer #(
        .FM_DEPTH (FM_DEPTH),
        .FM_WIDTH (FM_WIDTH)
    ) u_lb (
        .clk   (clk),
        .wr_en (data_in_valid),
        .col   (eff_col),
        .din   (data_in),
        .row1  (lb_r1),
        .row2  (lb_r2)
    );

    always_comb begin
        for (int unsigned ch = 0; ch < FM_DEPTH; ch++) begin
            nc[0][ch] = lb_r2[ch];
            nc[1][ch] = lb_r1[ch];
            nc[2][ch] = data_in[ch];
            for (int unsigned i = 0; i < WIN; i++) begin
                win[ch][WIN*i]     = (row_ok[i] && col2_ok) ? w2[i][ch] : '0;
                win[ch][WIN*i + 1] = (row_ok[i] && col1_ok) ? w1[i][ch] : '0;
                win[ch][WIN*i + 2] = row_ok[i] ? nc[i][ch] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (data_in_valid) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                for (int unsigned ch = 0; ch < FM_DEPTH; ch++) begin
                    w2[i][ch] <= w1[i][ch];
                    w1[i][ch] <= nc[i][ch];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            col            <= '0;
            row            <= '0;
            mode           <= STRIDE1;
            armed          <= 1'b1;
            data_out_valid <= 1'b0;
            vs_next        <= 1'b0;
            for (int unsigned ch = 0; ch < FM_DEPTH; ch++) begin
                for (int unsigned k = 0; k < CORE_SIZE; k++) data_out[ch][k] <= '0;
                for (int unsigned k = 0; k < 4; k++) C[ch][k] <= '0;
            end
        end else begin
            data_out_valid <= fire;
            vs_next        <= fire & eff_arm;
            mode           <= eff_mode;
            if (data_in_valid) begin
                col   <= at_row_end ? '0 : eff_col + 1'b1;
                row   <= wrap ? '0 : (at_row_end ? eff_row + 1'b1 : eff_row);
                armed <= wrap | (eff_arm & ~fire);
            end else if (verticle_sync) begin
                col   <= '0;
                row   <= '0;
                armed <= 1'b1;
            end
            if (fire) begin
                for (int unsigned ch = 0; ch < FM_DEPTH; ch++) begin
                    for (int unsigned k = 0; k < WIN*WIN; k++) data_out[ch][k] <= win[ch][k];
                    C[ch][0] <= win[ch][4];
                    C[ch][1] <= win[ch][5];
                    C[ch][2] <= win[ch][7];
                    C[ch][3] <= win[ch][8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wrapper.sv
// Directed bench for the sliding-window generator using ramp and random frames.
module tb_wrapper;

    localparam int D = 4;
    localparam int W = 56;

    logic clk = 1'b0;
    logic rstn, verticle_sync, mode_in, data_in_valid;
    logic signed [15:0] data_in  [D];
    logic               data_out_valid, vs_next;
    logic signed [15:0] data_out [D][9];
    logic signed [15:0] C        [D][4];

    int total = 0;
    int bad   = 0;
    int nv, ns, ne;

    always #5 clk = ~clk;

    wrapper #(
        .FM_DEPTH  (D),
        .FM_WIDTH  (W),
        .CORE_SIZE (9)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .verticle_sync  (verticle_sync),
        .mode_in        (mode_in),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .data_out_valid (data_out_valid),
        .vs_next        (vs_next),
        .data_out       (data_out),
        .C              (C)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        return (r < 0 || c < 0) ? 0 : W * r + c + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input int v);
        for (int ch = 0; ch < D; ch++) data_in[ch] = 16'(v);
    endtask

    task automatic sync_idle(input logic m);
        verticle_sync = 1'b1;
        mode_in       = m;
        data_in_valid = 1'b0;
        tick();
        verticle_sync = 1'b0;
    endtask

    // Feeds one full ramp frame and tallies valids, vs pulses and window errors.
    task automatic run_frame(input bit s2, output int nvalid, output int nvs, output int nerr);
        bit expv;
        nvalid = 0; nvs = 0; nerr = 0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_all(px(r, c));
                data_in_valid = 1'b1;
                tick();
                expv = !s2 || ((r % 2 == 1) && (c % 2 == 1));
                if (data_out_valid !== expv) nerr++;
                if (vs_next === 1'b1) nvs++;
                if (data_out_valid === 1'b1) begin
                    nvalid++;
                    if (vs_next !== (nvalid == 1)) nerr++;
                    for (int ch = 0; ch < D; ch++) begin
                        for (int k = 0; k < 9; k++)
                            if (data_out[ch][k] !== 16'(px(r - 2 + k / 3, c - 2 + k % 3))) nerr++;
                        if (C[ch][0] !== 16'(px(r - 1, c - 1))) nerr++;
                        if (C[ch][1] !== 16'(px(r - 1, c)))     nerr++;
                        if (C[ch][2] !== 16'(px(r, c - 1)))     nerr++;
                        if (C[ch][3] !== 16'(px(r, c)))         nerr++;
                    end
                end
                if (!s2 && r == 0 && c == 0) begin
                    check("s1 origin vs_next", vs_next, 1);
                    for (int k = 0; k < 8; k++) check("s1 origin pad", data_out[0][k], 0);
                    check("s1 origin d8", data_out[D-1][8], 1);
                end
                if (!s2 && r == 2 && c == 2) begin
                    check("s1 (2,2) d0", data_out[0][0], 1);
                    check("s1 (2,2) d2", data_out[0][2], 3);
                    check("s1 (2,2) d3", data_out[0][3], 57);
                    check("s1 (2,2) d5", data_out[0][5], 59);
                    check("s1 (2,2) d7", data_out[D-1][7], 114);
                    check("s1 (2,2) d8", data_out[D-1][8], 115);
                end
                if (s2 && r == 1 && c == 1) begin
                    check("s2 first valid", data_out_valid, 1);
                    check("s2 first vs", vs_next, 1);
                    check("s2 C0", C[0][0], 1);
                    check("s2 C1", C[0][1], 2);
                    check("s2 C2", C[0][2], 57);
                    check("s2 C3", C[D-1][3], 58);
                end
            end
        end
        data_in_valid = 1'b0;
    endtask

    initial begin : stim
        logic signed [15:0] cur  [D];
        logic signed [15:0] prev [D];
        int e;

        rstn = 1'b1; verticle_sync = 1'b0; mode_in = 1'b0; data_in_valid = 1'b0;
        drive_all(0);
        repeat (2) tick();
        check("reset valid", data_out_valid, 0);
        check("reset vs", vs_next, 0);
        check("reset d8", data_out[0][8], 0);
        check("reset C3", C[0][3], 0);
        rstn = 1'b0;
        tick();

        // Stride-1 frame followed by a wrap into a second frame with no sync.
        sync_idle(1'b0);
        run_frame(1'b0, nv, ns, ne);
        check("s1 valids", nv, 3136);
        check("s1 vs count", ns, 1);
        check("s1 window errs", ne, 0);
        run_frame(1'b0, nv, ns, ne);
        check("wrap valids", nv, 3136);
        check("wrap vs count", ns, 1);
        check("wrap window errs", ne, 0);

        sync_idle(1'b1);
        run_frame(1'b1, nv, ns, ne);
        check("s2 valids", nv, 784);
        check("s2 vs count", ns, 1);
        check("s2 window errs", ne, 0);

        // Sparse random input along row 0.
        sync_idle(1'b0);
        e = 0;
        for (int n = 0; n < 20; n++) begin
            for (int ch = 0; ch < D; ch++) cur[ch] = 16'($urandom_range(0, 65535));
            for (int ch = 0; ch < D; ch++) data_in[ch] = cur[ch];
            data_in_valid = 1'b1;
            tick();
            data_in_valid = 1'b0;
            if (n == 0) begin
                check("sparse first valid", data_out_valid, 1);
                check("sparse first d8", data_out[0][8], cur[0]);
                check("sparse first d7", data_out[0][7], 0);
            end
            if (data_out_valid !== 1'b1) e++;
            for (int ch = 0; ch < D; ch++) begin
                if (data_out[ch][8] !== cur[ch]) e++;
                if (n > 0 && data_out[ch][7] !== prev[ch]) e++;
                if (data_out[ch][4] !== 16'sd0) e++;
            end
            repeat (7) begin
                tick();
                if (data_out_valid !== 1'b0 || data_out[0][8] !== cur[0] || vs_next !== 1'b0) e++;
            end
            for (int ch = 0; ch < D; ch++) prev[ch] = cur[ch];
        end
        check("sparse errs", e, 0);

        // Sync after 100 pixels of a frame.
        sync_idle(1'b0);
        for (int p = 0; p < 100; p++) begin
            drive_all(px(p / W, p % W));
            data_in_valid = 1'b1;
            tick();
        end
        check("pre-sync no vs", vs_next, 0);
        sync_idle(1'b0);
        drive_all(999);
        data_in_valid = 1'b1;
        tick();
        check("midsync vs", vs_next, 1);
        check("midsync valid", data_out_valid, 1);
        for (int k = 0; k < 8; k++) check("midsync pad", data_out[0][k], 0);
        check("midsync d8", data_out[D-1][8], 999);
        check("midsync C2", C[0][2], 0);
        drive_all(1000);
        tick();
        check("midsync next vs", vs_next, 0);
        check("midsync next d7", data_out[0][7], 999);
        check("midsync next d8", data_out[0][8], 1000);

        // Sync and valid in the same cycle.
        verticle_sync = 1'b1;
        drive_all(777);
        tick();
        verticle_sync = 1'b0;
        check("syncvalid vs", vs_next, 1);
        check("syncvalid d7", data_out[0][7], 0);
        check("syncvalid d8", data_out[0][8], 777);
        data_in_valid = 1'b0;

        // Asynchronous reset while streaming, then a fresh frame without sync.
        sync_idle(1'b0);
        for (int p = 0; p < 30; p++) begin
            drive_all(px(0, p));
            data_in_valid = 1'b1;
            tick();
        end
        data_in_valid = 1'b0;
        check("pre-reset valid", data_out_valid, 1);
        rstn = 1'b1;
        #1;
        check("async reset valid", data_out_valid, 0);
        check("async reset d8", data_out[0][8], 0);
        check("async reset C3", C[D-1][3], 0);
        #1;
        rstn = 1'b0;
        tick();
        run_frame(1'b0, nv, ns, ne);
        check("post-reset valids", nv, 3136);
        check("post-reset vs count", ns, 1);
        check("post-reset window errs", ne, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrapper.md
# wrapper

Sliding-window generator at the input of each ResNet convolution stage. It accepts a raster-scan feature map one pixel per valid beat, with all FM_DEPTH channels in parallel. Each beat it emits a CORE_SIZE = 3×3 neighbourhood per channel for the convolution engine, plus a 2×2 neighbourhood per channel (C) for the downsampling shortcut. It also forwards a frame-start pulse to the next layer.

## Interface
- FM_DEPTH, 64: channels per pixel.
- FM_WIDTH, 56: frame width and height in pixels (square frame).
- CORE_SIZE, 9: window elements per channel. Fixed 3×3; any other value is unsupported.
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset. Asynchronous, active-high (1 = reset), despite the name.
- verticle_sync  in  1  frame start. While high, the row/col counters are forced to 0 and mode_in is latched.
- mode_in  in  1  0 = stride 1, 1 = stride 2. Sampled only while verticle_sync is high.
- data_in_valid  in  1  qualifies data_in for one pixel.
- data_in  in  [FM_DEPTH] × signed 16  one pixel, all channels.
- data_out_valid  out  1  window valid.
- vs_next  out  1  one-cycle pulse with the first data_out_valid of a frame.
- data_out  out  [FM_DEPTH][CORE_SIZE] × signed 16  3×3 window.
- C  out  [FM_DEPTH][4] × signed 16  2×2 window.

## Operation
- Counters: col 0..FM_WIDTH-1, row 0..FM_WIDTH-1, giving the position of the next accepted pixel.
  - Each accepted pixel increments col.
  - At col = FM_WIDTH-1, col wraps to 0 and row increments.
  - At (FM_WIDTH-1, FM_WIDTH-1) both counters wrap to 0. A new frame may therefore follow without a sync.
- verticle_sync high: counters go to (0,0), mode register <= mode_in, and the first-output flag is armed.
  - If data_in_valid is also high in the same cycle, that pixel is accepted as (0,0) of the new frame.
- Line buffers: two rows of FM_WIDTH pixels.
  - On accept at column c: read LB1[c] (row r-1) and LB2[c] (row r-2), then write LB2[c] <= LB1[c] and LB1[c] <= data_in.
- Window registers: three rows × columns c-1 and c-2, shifted on each accept. No other state changes without data_in_valid.
- Window for accepted pixel (r,c): data_out[ch][3i+j] = pixel(r-2+i, c-2+j), for i,j in 0..2.
  - Any position with negative row or column is forced to 0; this is top/left zero padding of 2.
  - data_out[ch][8] is the current pixel.
- C[ch] = {pixel(r-1,c-1), pixel(r-1,c), pixel(r,c-1), pixel(r,c)} for indices 0..3, with the same zero masking.
- Output qualification:
  - Stride 1: every accepted pixel produces data_out_valid.
  - Stride 2: data_out_valid only when r and c are both odd, giving (FM_WIDTH/2)² outputs per frame.
- vs_next rises with the first data_out_valid after verticle_sync (or after a wrap), then disarms.
- Values are passed through unchanged; no arithmetic is performed.

## Timing
- Latency: data_out, C, data_out_valid and vs_next are registered and appear exactly 1 cycle after the accepting clock edge.
- Outputs hold their values between valids. data_out_valid and vs_next are high for one cycle only.
- Back-to-back valids (one per cycle) are supported. Arbitrary gaps are supported.
- Reset, including mid-frame:
  - All outputs go to 0; counters go to 0; mode goes to 0 (stride 1); the first-output flag is armed.
  - Line-buffer contents need not be cleared, because masking hides them.
- verticle_sync mid-frame: the partial frame is abandoned and the next pixel becomes (0,0).

## Structure
- Package wrapper_pkg:
  - DATA_W = 16.
  - typedef pixel_t = signed [DATA_W-1:0] [FM_DEPTH].
  - Constant WIN = 3.
- One sub-module, wrapper_line_buffer: a FM_WIDTH-deep, two-row memory with read-then-write at a column index. The wrapper instantiates it once.

## Test plan
- Ramp stride 1: reset, sync with mode_in = 0, then feed pixel (r,c) with every channel = 56r+c+1.
  - At (2,2), data_out[ch] = {1,2,3,57,58,59,113,114,115}.
  - At (0,0), data_out = {0,0,0,0,0,0,0,0,1} and vs_next = 1.
  - Exactly 3136 valids per frame.
- Stride 2: same frame with mode_in = 1.
  - The first valid is at (1,1) with C[ch] = {1,2,57,58}.
  - 784 valids per frame; vs_next only on the first.
- Sparse input: one valid every 8 cycles with random data.
  - Each output appears 1 cycle after its input; data_out[ch][8] equals that input.
  - Outputs hold between valids.
- Sync mid-frame: assert verticle_sync after 100 pixels.
  - The next pixel is treated as (0,0): window all zero except element 8, and vs_next pulses.
- Reset mid-frame: assert rstn = 1 during streaming.
  - All outputs read 0 immediately (asynchronous).
  - After release, behaviour matches a fresh stride-1 frame.
- Frame wrap without sync: two consecutive ramp frames.
  - The second frame's (0,0) window is zero-padded (no leakage from the first frame), and vs_next pulses again.
